// File: rtl/obf_key_mux_bank_if.sv
// Key-load handshake and obfuscated-net bus for obf_key_mux_bank.
`timescale 1ns/1ps
interface obf_key_mux_bank_if #(
  parameter int unsigned NCH = 4
);
  localparam int unsigned CW = $clog2(2 * NCH + 1);

  logic           key_bit;
  logic           key_vld;
  logic           key_commit;
  logic           key_clr;
  logic [NCH-1:0] n_in;
  logic [NCH-1:0] n_obf;
  logic           key_ready;
  logic           key_err;
  logic [CW-1:0]  key_cnt;

  // Key source and net driver side
  modport master (
    output key_bit, key_vld, key_commit, key_clr, n_in,
    input  n_obf, key_ready, key_err, key_cnt
  );

  // Substitution bank side
  modport slave (
    input  key_bit, key_vld, key_commit, key_clr, n_in,
    output n_obf, key_ready, key_err, key_cnt
  );
endinterface

// File: rtl/obf_key_mux_bank.sv
// Key-controlled net-substitution bank: serial key load, explicit commit,
// per-channel pass / invert / const1 / const0 selection on NCH nets.
`timescale 1ns/1ps
module obf_key_mux_bank #(
  parameter int unsigned NCH     = 4,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  obf_key_mux_bank_if.slave   bus
);
  localparam int unsigned KW = 2 * NCH;
  localparam int unsigned CW = $clog2(2 * NCH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(KW);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_ARMED,
    S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  shift_q, shift_d;
  logic [KW-1:0]  akey_q, akey_d;
  logic           ready_q, err_q;
  logic [NCH-1:0] sub_c;
  logic [NCH-1:0] obf_c;

  // State, shift register, applied key and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      shift_q <= '0;
      akey_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      akey_q  <= akey_d;
      ready_q <= (state_d == S_ARMED);
      err_q   <= (state_d == S_ERROR);
    end
  end

  // Key-load sequencing: clear wins, a simultaneous shift+commit is an error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    akey_d  = akey_q;
    if (bus.key_clr) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
      shift_d = '0;
      akey_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY, S_LOAD: begin
          if (bus.key_vld && bus.key_commit) begin
            state_d = S_ERROR;
          end else if (bus.key_vld) begin
            if (cnt_q == CNT_FULL) begin
              state_d = S_ERROR;
            end else begin
              for (int unsigned j = 0; j < KW; j++) begin
                if (cnt_q == CW'(j)) shift_d[j] = bus.key_bit;
              end
              cnt_d   = cnt_q + CW'(1);
              state_d = S_LOAD;
            end
          end else if (bus.key_commit) begin
            if (cnt_q == CNT_FULL) begin
              akey_d  = shift_q;
              state_d = S_ARMED;
            end else begin
              state_d = S_ERROR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel substitution from the applied key: D0 forces a constant ~D1,
  // otherwise the net passes, inverted when D1 is set
  always_comb begin
    sub_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sub_c[i] = akey_q[2*i] ? ~akey_q[2*i+1] : (bus.n_in[i] ^ akey_q[2*i+1]);
    end
    obf_c = (state_q == S_ARMED) ? sub_c : '0;
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [NCH-1:0] obf_q;

      // Registered output; a clear in flight suppresses the last substituted value
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) obf_q <= '0;
        else        obf_q <= bus.key_clr ? '0 : obf_c;
      end

      assign bus.n_obf = obf_q;
    end else begin : g_comb
      assign bus.n_obf = obf_c;
    end
  endgenerate

  assign bus.key_ready = ready_q;
  assign bus.key_err   = err_q;
  assign bus.key_cnt   = cnt_q;
endmodule

// File: tb/tb_obf_key_mux_bank.sv
// Directed bench for obf_key_mux_bank: registered and combinational variants
// driven in lockstep and checked against a queue-based key-load model.
`timescale 1ns/1ps
module tb_obf_key_mux_bank;
  localparam int unsigned NCH = 4;
  localparam int unsigned KW  = 2 * NCH;
  localparam int M_EMPTY = 0, M_LOAD = 1, M_ARMED = 2, M_ERROR = 3;
  localparam logic [KW-1:0] GOOD_KEY = 8'b1101_1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           key_bit = 1'b0;
  logic           key_vld = 1'b0;
  logic           key_commit = 1'b0;
  logic           key_clr = 1'b0;
  logic [NCH-1:0] n_in = '0;
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  obf_key_mux_bank_if #(.NCH(NCH)) bus_r ();
  obf_key_mux_bank_if #(.NCH(NCH)) bus_c ();

  assign bus_r.key_bit    = key_bit;
  assign bus_r.key_vld    = key_vld;
  assign bus_r.key_commit = key_commit;
  assign bus_r.key_clr    = key_clr;
  assign bus_r.n_in       = n_in;
  assign bus_c.key_bit    = key_bit;
  assign bus_c.key_vld    = key_vld;
  assign bus_c.key_commit = key_commit;
  assign bus_c.key_clr    = key_clr;
  assign bus_c.n_in       = n_in;

  obf_key_mux_bank #(.NCH(NCH), .REG_OUT(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
  obf_key_mux_bank #(.NCH(NCH), .REG_OUT(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel rule straight from the key table
  function automatic logic [NCH-1:0] subst(input logic [NCH-1:0] n, input logic [KW-1:0] k);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      case ({k[2*i], k[2*i+1]})
        2'b00:   r[i] = n[i];
        2'b01:   r[i] = ~n[i];
        2'b10:   r[i] = 1'b1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Model: accepted bits kept in a queue, count is its length
  int             m_st = M_EMPTY;
  bit             m_bits[$];
  logic [KW-1:0]  m_key = '0;
  logic [NCH-1:0] m_obf_r = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = M_EMPTY;
      m_bits.delete();
      m_key = '0;
      m_obf_r = '0;
    end else begin
      m_obf_r = (m_st == M_ARMED && !key_clr) ? subst(n_in, m_key) : '0;
      if (key_clr) begin
        m_st = M_EMPTY;
        m_bits.delete();
        m_key = '0;
      end else if (m_st == M_EMPTY || m_st == M_LOAD) begin
        if (key_vld && key_commit) m_st = M_ERROR;
        else if (key_vld) begin
          if (m_bits.size() == KW) m_st = M_ERROR;
          else begin
            m_bits.push_back(key_bit);
            m_st = M_LOAD;
          end
        end else if (key_commit) begin
          if (m_bits.size() == KW) begin
            for (int i = 0; i < KW; i++) m_key[i] = m_bits[i];
            m_st = M_ARMED;
          end else m_st = M_ERROR;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("cnt_r",   32'(bus_r.key_cnt),   32'(m_bits.size()));
    chk("cnt_c",   32'(bus_c.key_cnt),   32'(m_bits.size()));
    chk("ready_r", 32'(bus_r.key_ready), 32'(m_st == M_ARMED));
    chk("ready_c", 32'(bus_c.key_ready), 32'(m_st == M_ARMED));
    chk("err_r",   32'(bus_r.key_err),   32'(m_st == M_ERROR));
    chk("err_c",   32'(bus_c.key_err),   32'(m_st == M_ERROR));
    chk("obf_r",   32'(bus_r.n_obf),     32'(m_obf_r));
    chk("obf_c",   32'(bus_c.n_obf),     32'((m_st == M_ARMED) ? subst(n_in, m_key) : 4'b0000));
  end

  task automatic cyc(input logic v, input logic b, input logic c, input logic k);
    key_vld = v; key_bit = b; key_commit = c; key_clr = k;
    @(posedge clk);
    #2;
    key_vld = 1'b0; key_commit = 1'b0; key_clr = 1'b0;
  endtask

  task automatic load(input logic [KW-1:0] k, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, k[i], 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cnt",   32'(bus_r.key_cnt),   32'd0);
    chk("rst_ready", 32'(bus_r.key_ready), 32'd0);
    chk("rst_err",   32'(bus_r.key_err),   32'd0);
    chk("rst_obf_r", 32'(bus_r.n_obf),     32'd0);
    chk("rst_obf_c", 32'(bus_c.n_obf),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Good load and substitution
    load(GOOD_KEY, KW);
    chk("load_cnt", 32'(bus_r.key_cnt), 32'd8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("arm_ready", 32'(bus_r.key_ready), 32'd1);
    chk("arm_obf_r_lat", 32'(bus_r.n_obf), 32'd0);
    chk("arm_obf_c_n0", 32'(bus_c.n_obf), 32'h6);
    n_in = 4'b1010;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("map_1010_r", 32'(bus_r.n_obf), 32'h4);
    chk("map_1010_c", 32'(bus_c.n_obf), 32'h4);
    n_in = 4'b0101;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("map_0101_r", 32'(bus_r.n_obf), 32'h7);

    // Armed lock-in
    load(8'hFF, 3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("lock_cnt",   32'(bus_r.key_cnt),   32'd8);
    chk("lock_ready", 32'(bus_r.key_ready), 32'd1);
    chk("lock_obf_r", 32'(bus_r.n_obf),     32'h7);

    // Async reset while armed
    rst_n = 1'b0;
    #1;
    chk("areset_obf_c", 32'(bus_c.n_obf),     32'd0);
    chk("areset_obf_r", 32'(bus_r.n_obf),     32'd0);
    chk("areset_ready", 32'(bus_c.key_ready), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    load(GOOD_KEY, KW);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rearm_ready", 32'(bus_c.key_ready), 32'd1);
    chk("rearm_obf_c", 32'(bus_c.n_obf),     32'h7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rearm_obf_r", 32'(bus_r.n_obf),     32'h7);

    // Clear while armed
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_obf_r", 32'(bus_r.n_obf),     32'd0);
    chk("clr_obf_c", 32'(bus_c.n_obf),     32'd0);
    chk("clr_ready", 32'(bus_r.key_ready), 32'd0);

    // Early commit
    load(GOOD_KEY, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("early_err",   32'(bus_r.key_err),   32'd1);
    chk("early_ready", 32'(bus_r.key_ready), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("early_cnt",   32'(bus_r.key_cnt),   32'd5);
    chk("early_obf_c", 32'(bus_c.n_obf),     32'd0);

    // Overflow
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    load(8'hA5, KW);
    chk("ovf_8_err", 32'(bus_r.key_err), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_9_err", 32'(bus_r.key_err), 32'd1);
    chk("ovf_9_cnt", 32'(bus_r.key_cnt), 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr_cnt", 32'(bus_r.key_cnt), 32'd0);
    chk("ovf_clr_err", 32'(bus_r.key_err), 32'd0);

    // Simultaneous strobes
    load(GOOD_KEY, KW);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("simA_err", 32'(bus_r.key_err), 32'd1);
    chk("simA_cnt", 32'(bus_r.key_cnt), 32'd8);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("simB_cnt", 32'(bus_r.key_cnt), 32'd0);
    chk("simB_err", 32'(bus_r.key_err), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("simB_empty_vld", 32'(bus_r.key_cnt), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sim_empty_err", 32'(bus_r.key_err), 32'd1);
    chk("sim_empty_cnt", 32'(bus_r.key_cnt), 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
